fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Fetch stage of the 5-stage pipelined RV32I core: PC register, next-PC select, IF/ID pipeline register.
//  Consumes stall_f/stall_d/flush_d from the hazard unit and pc_src_e/targets from the execute stage.
//  Drives the instruction-memory address and feeds decode with instr_d/pc_d/pc_plus4_d/valid_d.
//  Keeps saturating stall and flush event counters for performance debug.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR 32'h0000_0013  bubble instruction (addi x0,x0,0) inserted on reset/flush
//  CNT_W     32             width of stall_cnt / flush_cnt
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      asynchronous active-high reset
//  stall_f      in   1      hold PC (from hazard unit)
//  stall_d      in   1      hold IF/ID register (from hazard unit)
//  flush_d      in   1      clear IF/ID register to bubble (from hazard unit)
//  pc_src_e     in   2      next-PC select from EX: 00 pc+4, 01 pc_target_e, 10 jalr, 11 pc+4
//  pc_target_e  in   32     branch/JAL target (pc_e + imm)
//  alu_result_e in   32     JALR target before LSB clear
//  imem_addr    out  32     instruction memory address (= pc_f)
//  imem_rdata   in   32     instruction word, combinational read of imem_addr
//  pc_f         out  32     current fetch PC
//  instr_d      out  32     instruction in decode
//  pc_d         out  32     PC of instr_d
//  pc_plus4_d   out  32     pc_d + 4
//  valid_d      out  1      1 = instr_d is a real fetched instruction, 0 = bubble
//  stall_cnt    out  CNT_W  cycles IF/ID was held
//  flush_cnt    out  CNT_W  cycles IF/ID was flushed
// BEHAVIOUR
//  Reset (async, immediate): pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, counters=0.
//  imem_addr = pc_f combinationally; pc_plus4_f = pc_f + 32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0).
//  Next PC: 01 -> pc_target_e; 10 -> {alu_result_e[31:1],1'b0}; 00/11 -> pc_plus4_f.
//  PC register priority per edge:
//   1. pc_src_e==01 or 10 (redirect): pc_f <= target, EVEN IF stall_f=1 (redirect beats load-use stall).
//   2. else stall_f=1: pc_f holds.
//   3. else pc_f <= pc_plus4_f.
//  IF/ID register priority per edge:
//   1. flush_d=1: instr_d<=NOP_INSTR, pc_d<=0, pc_plus4_d<=0, valid_d<=0 (beats stall_d).
//   2. else stall_d=1: all IF/ID outputs hold.
//   3. else instr_d<=imem_rdata, pc_d<=pc_f, pc_plus4_d<=pc_plus4_f, valid_d<=1.
//  Latency: instruction at pc_f appears on instr_d one edge later; redirect -> target fetched next cycle,
//   its instruction on instr_d two edges after pc_src_e asserts.
//  stall_f and stall_d are independent inputs; block must not assume they are equal.
//  Counters: stall_cnt +1 on edge with stall_d=1 & flush_d=0; flush_cnt +1 on edge with flush_d=1;
//   both saturate at all-ones (no wrap). Counters do not affect datapath.
//  Reset asserted mid-stall/flush: all state returns to reset values at once; first fetch after
//   deassert is RESET_PC, valid_d rises on the first edge after rst falls.
//  Target alignment is not checked; bit 1 of a target passes through unchanged.
// TESTING
//  Reset release, no stalls, imem returns addr^32'hA5A5_0000 -> pc_f 0,4,8,..., instr_d/pc_d follow 1 cycle behind, valid_d=1 from edge 1.
//  stall_f=stall_d=1 for 2 cycles at pc_f=0x10 -> pc_f stays 0x10, instr_d/pc_d(0xC) hold, stall_cnt=2.
//  pc_src_e=01, pc_target_e=0x200, flush_d=1 at pc_f=0x24 -> pc_f=0x200 next, instr_d=0x13, valid_d=0, flush_cnt+1.
//  pc_src_e=10, alu_result_e=0x301 with stall_f=1 -> pc_f=0x300 (redirect wins, LSB cleared).
//  flush_d=1 and stall_d=1 same cycle -> bubble loaded, stall_cnt unchanged, flush_cnt+1.
//  pc_f=0xFFFF_FFFC, no stall -> pc_f wraps to 0x0, pc_plus4_d=0x0; CNT_W=2 with 5 stalls -> stall_cnt=3; rst mid-stall -> all reset values.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Control, redirect, instruction-memory and IF/ID bundle
//                for the RV32I fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic [1:0]        pc_src_e;
    logic [31:0]       pc_target_e;
    logic [31:0]       alu_result_e;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       pc_f;
    logic [31:0]       instr_d;
    logic [31:0]       pc_d;
    logic [31:0]       pc_plus4_d;
    logic              valid_d;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Environment side: hazard unit, execute stage and instruction memory
    modport master (
        output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, alu_result_e,
        output imem_rdata,
        input  imem_addr, pc_f, instr_d, pc_d, pc_plus4_d, valid_d,
        input  stall_cnt, flush_cnt
    );

    // Fetch stage side
    modport slave (
        input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, alu_result_e,
        input  imem_rdata,
        output imem_addr, pc_f, instr_d, pc_d, pc_plus4_d, valid_d,
        output stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32I fetch stage - PC register, next-PC select, IF/ID
//                register and saturating stall/flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_stage_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      r_pc_f;
    logic [31:0]      r_instr_d;
    logic [31:0]      r_pc_d;
    logic [31:0]      r_pc_plus4_d;
    logic             r_valid_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [31:0]      w_pc_plus4_f;
    logic [31:0]      w_pc_target;
    logic             w_redirect;
    logic             w_unused_alu_lsb;

    assign w_pc_plus4_f     = r_pc_f + 32'd4;
    assign w_unused_alu_lsb = bus.alu_result_e[0];

    always_comb begin
        w_redirect  = 1'b0;
        w_pc_target = w_pc_plus4_f;
        case (bus.pc_src_e)
            2'b01: begin
                w_redirect  = 1'b1;
                w_pc_target = bus.pc_target_e;
            end
            2'b10: begin
                w_redirect  = 1'b1;
                w_pc_target = {bus.alu_result_e[31:1], 1'b0};
            end
            default: begin
                w_redirect  = 1'b0;
                w_pc_target = w_pc_plus4_f;
            end
        endcase
    end

    // A taken redirect must win over a load-use stall, or the branch is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_f <= RESET_PC;
        end else if (w_redirect) begin
            r_pc_f <= w_pc_target;
        end else if (!bus.stall_f) begin
            r_pc_f <= w_pc_plus4_f;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (bus.flush_d) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (!bus.stall_d) begin
            r_instr_d    <= bus.imem_rdata;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4_f;
            r_valid_d    <= 1'b1;
        end
    end

    // A flush overrides a hold, so it is not counted as a stall cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stall_d && !bus.flush_d && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (bus.flush_d && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.imem_addr  = r_pc_f;
    assign bus.pc_f       = r_pc_f;
    assign bus.instr_d    = r_instr_d;
    assign bus.pc_d       = r_pc_d;
    assign bus.pc_plus4_d = r_pc_plus4_d;
    assign bus.valid_d    = r_valid_d;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed and random bench for fetch_stage against a
//                cycle-level reference model; a second copy with 2-bit
//                counters exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_NOP     = 32'h0000_0013;
    localparam logic [31:0] c_MEM_XOR = 32'hA5A5_0000;

    logic clk;
    logic rst;

    fetch_stage_if #(.CNT_W(32)) ifc ();
    fetch_stage_if #(.CNT_W(2))  ifs ();

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(c_NOP), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(c_NOP), .CNT_W(2)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (ifs.slave)
    );

    assign ifc.imem_rdata   = ifc.imem_addr ^ c_MEM_XOR;
    assign ifs.imem_rdata   = ifs.imem_addr ^ c_MEM_XOR;
    assign ifs.stall_f      = ifc.stall_f;
    assign ifs.stall_d      = ifc.stall_d;
    assign ifs.flush_d      = ifc.flush_d;
    assign ifs.pc_src_e     = ifc.pc_src_e;
    assign ifs.pc_target_e  = ifc.pc_target_e;
    assign ifs.alu_result_e = ifc.alu_result_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
    logic        m_valid;
    longint      m_scnt, m_fcnt, m_scnt2, m_fcnt2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = c_NOP;
        m_pcd   = 32'h0;
        m_pcp4  = 32'h0;
        m_valid = 1'b0;
        m_scnt  = 0;
        m_fcnt  = 0;
        m_scnt2 = 0;
        m_fcnt2 = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_f"},       ifc.pc_f,       m_pc);
        check({tag, ".imem_addr"},  ifc.imem_addr,  m_pc);
        check({tag, ".instr_d"},    ifc.instr_d,    m_instr);
        check({tag, ".pc_d"},       ifc.pc_d,       m_pcd);
        check({tag, ".pc_plus4_d"}, ifc.pc_plus4_d, m_pcp4);
        check({tag, ".valid_d"},    {31'd0, ifc.valid_d}, {31'd0, m_valid});
        check({tag, ".stall_cnt"},  ifc.stall_cnt,  m_scnt[31:0]);
        check({tag, ".flush_cnt"},  ifc.flush_cnt,  m_fcnt[31:0]);
        check({tag, ".stall_cnt2"}, {30'd0, ifs.stall_cnt}, m_scnt2[31:0]);
        check({tag, ".flush_cnt2"}, {30'd0, ifs.flush_cnt}, m_fcnt2[31:0]);
    endtask

    // Drive one cycle at the falling edge, advance the model at the rising edge, check 1 ns later
    task automatic cycle(input logic sf, input logic sd, input logic fd,
                         input logic [1:0] src, input logic [31:0] tgt,
                         input logic [31:0] alu, input string tag);
        logic [31:0] n_pc;
        ifc.stall_f      = sf;
        ifc.stall_d      = sd;
        ifc.flush_d      = fd;
        ifc.pc_src_e     = src;
        ifc.pc_target_e  = tgt;
        ifc.alu_result_e = alu;
        @(posedge clk);
        if (src == 2'd1)      n_pc = tgt;
        else if (src == 2'd2) n_pc = alu & 32'hFFFF_FFFE;
        else if (sf)          n_pc = m_pc;
        else                  n_pc = m_pc + 32'd4;
        if (fd) begin
            m_instr = c_NOP; m_pcd = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
            m_fcnt++;
            if (m_fcnt2 < 3) m_fcnt2++;
        end else if (sd) begin
            m_scnt++;
            if (m_scnt2 < 3) m_scnt2++;
        end else begin
            m_instr = m_pc ^ c_MEM_XOR; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        m_pc = n_pc;
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "run");
    endtask

    initial begin
        ifc.stall_f = 1'b0; ifc.stall_d = 1'b0; ifc.flush_d = 1'b0;
        ifc.pc_src_e = 2'd0; ifc.pc_target_e = 32'h0; ifc.alu_result_e = 32'h0;
        rst = 1'b1;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line fetch 0,4,8,C,10
        run(4);
        check("seq.pc_f", ifc.pc_f, 32'h10);
        check("seq.pc_d", ifc.pc_d, 32'hC);

        // Two-cycle stall holds both PC and IF/ID
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "stall");
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "stall");
        check("stall.pc_f", ifc.pc_f, 32'h10);
        check("stall.cnt",  ifc.stall_cnt, 32'd2);

        // Branch redirect with flush
        run(5);
        check("pre_br.pc_f", ifc.pc_f, 32'h24);
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 32'h200, 32'h0, "branch");
        check("branch.pc_f", ifc.pc_f, 32'h200);
        check("branch.instr_d", ifc.instr_d, c_NOP);

        // JALR beats stall_f, LSB cleared
        cycle(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h301, "jalr");
        check("jalr.pc_f", ifc.pc_f, 32'h300);

        // Flush beats stall_d
        cycle(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, "flush_stall");

        // PC wrap at top of address space
        cycle(1'b0, 1'b0, 1'b0, 2'd1, 32'hFFFF_FFFC, 32'h0, "to_top");
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "wrap");
        check("wrap.pc_f", ifc.pc_f, 32'h0);
        check("wrap.pc_plus4_d", ifc.pc_plus4_d, 32'h0);

        // Saturation of the 2-bit counters
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "sat");
        check("sat.stall_cnt2", {30'd0, ifs.stall_cnt}, 32'd3);

        // Async reset during a stall
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "pre_rst");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "after_rst");
        check("after_rst.pc_d", ifc.pc_d, 32'h0);
        check("after_rst.valid_d", {31'd0, ifc.valid_d}, 32'd1);

        // Random traffic with independent stall_f / stall_d
        for (int i = 0; i < 400; i++) begin
            logic [1:0] src;
            int r;
            r = $urandom_range(0, 9);
            src = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r == 7) ? 2'd2 : 2'd3;
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 6) == 0), src, $urandom, $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
